// File: rtl/muldiv_seq_if.sv
// Handshake bundle between the EX stage and the iterative multiply sequencer.
// The pipeline side drives the request; the sequencer answers with stall/busy/done/result.
interface muldiv_seq_if #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 5
);
    logic              start;
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   op_a;
    logic [XLEN-1:0]   op_b;
    logic              kill;
    logic              stall;
    logic              busy;
    logic              done;
    logic [XLEN-1:0]   result;

    modport master (
        output start, ctrl, op_a, op_b, kill,
        input  stall, busy, done, result
    );

    modport slave (
        input  start, ctrl, op_a, op_b, kill,
        output stall, busy, done, result
    );
endinterface

// File: rtl/muldiv_seq.sv
// Radix-2 shift-add sequencer for MUL/MULH/MULHU/MULHSU: sign-magnitude operands,
// XLEN add/shift iterations, sign fix-up and word select in the final step.
module muldiv_seq #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    muldiv_seq_if.slave   bus
);
    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CTRL_W-1:0] C_MUL    = CTRL_W'(10);
    localparam logic [CTRL_W-1:0] C_MULH   = CTRL_W'(11);
    localparam logic [CTRL_W-1:0] C_MULHU  = CTRL_W'(12);
    localparam logic [CTRL_W-1:0] C_MULHSU = CTRL_W'(13);

    typedef enum logic [1:0] {IDLE, PREP, CALC, FIN} state_t;

    state_t              state_reg, state_next;
    logic [CTRL_W-1:0]   ctrl_reg;
    logic [XLEN-1:0]     a_reg, b_reg;
    logic [XLEN-1:0]     mcand_reg;
    logic [2*XLEN:0]     acc_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic                neg_reg;
    logic [XLEN-1:0]     result_reg;

    logic                is_mul, accept, done;
    logic                a_neg, b_neg;
    logic [XLEN-1:0]     a_mag, b_mag;
    logic [XLEN:0]       hi_sum;
    logic [2*XLEN:0]     acc_step;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     fin_word;

    assign is_mul = (bus.ctrl >= C_MUL) && (bus.ctrl <= C_MULHU + 1'b1) && (C_MULHSU == C_MULHU + 1'b1);
    assign accept = bus.start & is_mul & ~bus.kill;
    assign done   = (state_reg == FIN);

    assign bus.stall  = bus.start & is_mul & ~done & ~bus.kill;
    assign bus.busy   = (state_reg != IDLE);
    assign bus.done   = done;
    assign bus.result = result_reg;

    // Magnitudes of the latched operands; only MULH treats rs2 as signed.
    assign a_neg = ((ctrl_reg == C_MULH) || (ctrl_reg == C_MULHSU)) && a_reg[XLEN-1];
    assign b_neg = (ctrl_reg == C_MULH) && b_reg[XLEN-1];
    assign a_mag = a_neg ? -a_reg : a_reg;
    assign b_mag = b_neg ? -b_reg : b_reg;

    // One iteration: conditional add into the upper half, then shift {carry, acc} right.
    assign hi_sum   = acc_reg[2*XLEN:XLEN] + (acc_reg[0] ? {1'b0, mcand_reg} : '0);
    assign acc_step = {1'b0, hi_sum, acc_reg[XLEN-1:1]};
    assign prod     = neg_reg ? -acc_step[2*XLEN-1:0] : acc_step[2*XLEN-1:0];
    assign fin_word = (ctrl_reg == C_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = PREP;
            PREP: state_next = bus.kill ? IDLE : CALC;
            CALC: begin
                if (bus.kill)           state_next = IDLE;
                else if (cnt_reg == '0) state_next = FIN;
            end
            FIN:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_reg   <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            mcand_reg  <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            neg_reg    <= 1'b0;
            result_reg <= '0;
        end else begin
            if (state_reg == IDLE && accept) begin
                ctrl_reg <= bus.ctrl;
                a_reg    <= bus.op_a;
                b_reg    <= bus.op_b;
            end
            if (state_reg == PREP) begin
                mcand_reg <= a_mag;
                acc_reg   <= {{(XLEN+1){1'b0}}, b_mag};
                neg_reg   <= a_neg ^ b_neg;
                cnt_reg   <= CNT_W'(XLEN-1);
            end
            if (state_reg == CALC) begin
                acc_reg <= acc_step;
                cnt_reg <= cnt_reg - 1'b1;
            end
            // The product word is captured on the last iteration so it is valid with done.
            if (state_reg == CALC && state_next == FIN)
                result_reg <= fin_word;
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: randomized multiply ops against a wide-arithmetic model.
module tb_muldiv_seq;
    localparam int XLEN   = 32;
    localparam int CTRL_W = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_seq_if #(.XLEN(XLEN), .CTRL_W(CTRL_W)) bus ();

    muldiv_seq #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic [31:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // Reference: exact signed/unsigned product in wide arithmetic, then word select.
    function automatic logic [31:0] ref_model(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        logic signed [65:0] ea, eb, p;
        bit a_s, b_s;
        a_s = (c == 5'd11) || (c == 5'd13);
        b_s = (c == 5'd11);
        ea = a_s ? {{34{a[31]}}, a} : {34'b0, a};
        eb = b_s ? {{34{b[31]}}, b} : {34'b0, b};
        p  = ea * eb;
        return (c == 5'd10) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every done pulse pops one expected result.
    always @(negedge clk) begin : monitor
        logic [31:0] e;
        if (rst_n && bus.done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 result=0x%08h required no pending op", bus.result);
            end else begin
                e = exp_q.pop_front();
                $display("txn done result=0x%08h expected=0x%08h", bus.result, e);
                check("result", {32'b0, bus.result}, {32'b0, e});
            end
        end
    end

    // Issue one op with start held as the EX stage would, track latency and stall.
    task automatic run_op(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        int n;
        bit stall_ok, seen;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.ctrl = c; bus.op_a = a; bus.op_b = b; bus.kill = 1'b0;
        @(negedge clk);
        check("idle_at_issue", {63'b0, bus.busy}, 64'd0);
        stall_ok = (bus.stall == 1'b1);
        exp_q.push_back(ref_model(c, a, b));
        $display("txn issue ctrl=%0d a=0x%08h b=0x%08h", c, a, b);
        n = 0;
        seen = 0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            if (n == 5) begin
                bus.op_a = $urandom;
                bus.op_b = $urandom;
            end
            if (bus.done) seen = 1;
            else if (!bus.stall || !bus.busy) stall_ok = 0;
        end
        check("done_seen", {63'b0, seen}, 64'd1);
        check("latency", 64'(n), 64'd34);
        check("stall_held", {63'b0, stall_ok}, 64'd1);
        check("stall_low_on_done", {63'b0, bus.stall}, 64'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish required finish before timeout");
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic [31:0] prev;
        logic [4:0]  c;
        bit          flag;
        bus.start = 1'b0; bus.ctrl = '0; bus.op_a = '0; bus.op_b = '0; bus.kill = 1'b0;

        @(negedge clk);
        check("rst_busy",   {63'b0, bus.busy},  64'd0);
        check("rst_done",   {63'b0, bus.done},  64'd0);
        check("rst_result", {32'b0, bus.result}, 64'd0);
        check("rst_stall",  {63'b0, bus.stall}, 64'd0);
        rst_n = 1'b1;

        // Directed cases, back-to-back where consecutive.
        run_op(5'd10, 32'd7, 32'd6);
        run_op(5'd11, 32'h8000_0000, 32'h8000_0000);
        run_op(5'd12, 32'h8000_0000, 32'h8000_0000);
        run_op(5'd13, 32'h8000_0000, 32'h8000_0000);
        run_op(5'd11, 32'hFFFF_FFFF, 32'd3);
        run_op(5'd10, 32'hFFFF_FFFF, 32'd3);
        run_op(5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(5'd10, 32'd0, 32'd5);

        // Randomized ops interleaved with non-multiply codes that must be ignored.
        for (int i = 0; i < 30; i++) begin
            if ((i % 7) == 3) begin
                c = 5'($urandom_range(0, 27));
                if (c >= 5'd10) c = c + 5'd4;
                @(posedge clk); #1;
                bus.start = 1'b1; bus.ctrl = c;
                @(negedge clk);
                check("nonmul_stall", {63'b0, bus.stall}, 64'd0);
                @(negedge clk);
                check("nonmul_busy", {63'b0, bus.busy}, 64'd0);
                bus.start = 1'b0;
                $display("txn ignore ctrl=%0d", c);
            end
            run_op(5'(10 + $urandom_range(0, 3)), pick_operand(), pick_operand());
        end

        // Kill mid-CALC: no done, result held, busy drops next cycle.
        @(posedge clk); #1;
        bus.start = 1'b0;
        prev = bus.result;
        bus.start = 1'b1; bus.ctrl = 5'd10; bus.op_a = 32'd1234; bus.op_b = 32'd5678;
        @(negedge clk);
        check("kill_idle_at_issue", {63'b0, bus.busy}, 64'd0);
        repeat (10) @(negedge clk);
        check("kill_busy_before", {63'b0, bus.busy}, 64'd1);
        bus.kill = 1'b1;
        #1;
        check("kill_stall", {63'b0, bus.stall}, 64'd0);
        @(posedge clk); #1;
        bus.kill = 1'b0; bus.start = 1'b0;
        @(negedge clk);
        check("kill_busy_after", {63'b0, bus.busy}, 64'd0);
        check("kill_result_held", {32'b0, bus.result}, {32'b0, prev});
        flag = 1;
        repeat (40) begin
            @(negedge clk);
            if (bus.busy) flag = 0;
        end
        check("kill_stays_idle", {63'b0, flag}, 64'd1);
        $display("txn kill done, result held 0x%08h", prev);
        run_op(5'd13, 32'hFFFF_FFF0, 32'd16);

        // Reset mid-CALC with an ADD code presented.
        run_op(5'd10, 32'd7, 32'd6);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.ctrl = 5'd10; bus.op_a = 32'd123; bus.op_b = 32'd456;
        @(negedge clk);
        repeat (15) @(negedge clk);
        check("rst_mid_busy_before", {63'b0, bus.busy}, 64'd1);
        rst_n = 1'b0;
        bus.ctrl = 5'd0;
        #1;
        check("rst_mid_busy",   {63'b0, bus.busy},  64'd0);
        check("rst_mid_done",   {63'b0, bus.done},  64'd0);
        check("rst_mid_result", {32'b0, bus.result}, 64'd0);
        check("rst_mid_stall",  {63'b0, bus.stall}, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        flag = 1;
        repeat (40) begin
            @(negedge clk);
            if (bus.busy || bus.stall) flag = 0;
        end
        check("add_never_busy", {63'b0, flag}, 64'd1);
        bus.start = 1'b0;
        $display("txn reset mid-op, add ignored");

        repeat (5) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative sequencer for the M-extension multiply ops (MUL, MULH, MULHSU, MULHU), keyed by the 5-bit ALU control code produced by the ALU decoder.
- Sits beside the combinational ALU in EX. It replaces a single-cycle multiplier with a radix-2 shift-add engine of XLEN iterations.
- Stalls the pipeline while busy and returns one result per accepted operation.

Parameters:
- XLEN, 32, operand and result width.
- CTRL_W, 5, width of the ALU control code.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  EX stage holds a valid instruction.
- ctrl  in  CTRL_W  ALU control code. 10 = MUL, 11 = MULH, 12 = MULHU, 13 = MULHSU.
- op_a  in  XLEN  rs1 value.
- op_b  in  XLEN  rs2 value.
- kill  in  1  pipeline flush; aborts the operation in flight.
- stall  out  1  combinational; freezes the pipeline front end.
- busy  out  1  registered; sequencer is not in IDLE.
- done  out  1  registered; 1-cycle pulse, result valid.
- result  out  XLEN  registered product word, held until the next accept.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - state = IDLE; busy = 0, done = 0, result = 0.
  - Internal product, multiplicand, counter and negate flag are all 0.
- is_mul: is_mul = (ctrl is 10..13). For any other code the block ignores start and stall = 0.
- State IDLE:
  - If start & is_mul & ~kill, accept: latch ctrl, op_a and op_b, then go to PREP. busy rises next cycle.
- State PREP (1 cycle):
  - a_signed = ctrl in {11, 13}; b_signed = ctrl == 11.
  - Take magnitudes: |x| = -x when the operand is signed and its MSB = 1.
  - neg = (a_signed & a[MSB]) ^ (b_signed & b[MSB]).
  - Clear the 2*XLEN accumulator; counter = XLEN-1. Go to CALC.
- State CALC (XLEN cycles):
  - Each cycle: if multiplier bit 0 = 1, add the multiplicand into the upper accumulator half (keep carry).
  - Then shift the {carry, accumulator} pair right by 1.
  - Decrement the counter. At counter == 0 go to FIN.
- State FIN (1 cycle):
  - Full product p = neg ? -acc : acc, taken modulo 2^(2*XLEN).
  - result = p[XLEN-1:0] for MUL, otherwise p[2*XLEN-1:XLEN].
  - done = 1 for this cycle only. Next state IDLE.
- Latency: accept at cycle T gives done = 1 and a valid result at cycle T+XLEN+2. There is no pipelining; at most one operation is in flight.
- stall = start & is_mul & ~done & ~kill.
  - The pipeline advances on the done cycle.
  - No accept is possible while in FIN, so the same instruction is never re-issued.
- kill:
  - In any non-IDLE state, kill forces IDLE on the next edge, with no done and result unchanged.
  - In IDLE, kill blocks acceptance.
  - kill on the done cycle itself is ignored; done and result stand.
- Input changes: op_a, op_b and ctrl changing after acceptance have no effect.
- Arithmetic boundaries:
  - The magnitude of the most negative value, 0x8000_0000, is 0x8000_0000 as an unsigned value. The accumulator is 2*XLEN+1 bits wide to hold the carry.
  - A zero operand still takes the full latency.
- Reset mid-operation: returns to IDLE immediately, with all outputs at their reset values.

Test Plan:
- MUL, op_a = 7, op_b = 6 -> done exactly 34 cycles after accept, result = 0x0000_002A; stall high on cycles T..T+33, low at T+34.
- MULH, op_a = 0x8000_0000, op_b = 0x8000_0000 -> result = 0x4000_0000. MULHU with the same operands -> 0x4000_0000. MULHSU with the same operands -> 0xC000_0000.
- MULH, op_a = 0xFFFF_FFFF (-1), op_b = 3 -> result = 0xFFFF_FFFF; MUL of the same operands -> 0xFFFF_FFFD.
- Back-to-back: MULHU 0xFFFF_FFFF × 0xFFFF_FFFF (-> 0xFFFF_FFFE), then MUL 0 × 5 (-> 0). Exactly one done per op; the second accept occurs on the cycle after the first done.
- kill at cycle T+10 of a MUL -> no done pulse, busy = 0 at T+11, result keeps its prior value. A new op is accepted normally afterwards.
- Assert rst_n = 0 mid-CALC, then start with ctrl = 0 (ADD) -> all outputs return to 0 asynchronously. Afterwards, with ctrl = 0, stall stays 0 and busy never rises.
